// File: rtl/rot_coord_gen.sv
// rot_coord_gen: inverse-rotation source coordinate generator for a raster-scanned frame.
// Optional macro ROT_BOUNDS_CHECK_EN: flag/zero src coordinates that fall outside the image.
module rot_coord_gen #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int CW      = 8,
  parameter int LUT_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    aci_in,
  input  logic          eksi_in,
  output logic [2:0]    aci,
  output logic          eksi,
  output logic          mode_switch,
  input  logic [16:0]   trig_in,
  output logic [CW-1:0] dst_x,
  output logic [CW-1:0] dst_y,
  output logic [CW-1:0] src_x,
  output logic [CW-1:0] src_y,
  output logic          coord_valid,
  output logic          out_valid,
  input  logic          ready,
  output logic          busy,
  output logic          done
);

  localparam int PW = CW + 18;
  localparam int SW = CW + 19;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LCOS = 3'd1;
  localparam logic [2:0] S_LSIN = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0]    LAT  = 8'(LUT_LAT);
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(IMG_H - 1);

  localparam logic signed [CW:0] XC_OFF = (CW+1)'(IMG_W / 2);
  localparam logic signed [CW:0] YC_OFF = (CW+1)'(IMG_H / 2);

  localparam logic signed [SW-1:0] RND  = SW'(512);
  localparam logic signed [SW-1:0] XOFS = SW'(IMG_W / 2);
  localparam logic signed [SW-1:0] YOFS = SW'(IMG_H / 2);
  localparam logic signed [SW-1:0] XLIM = SW'(IMG_W);
  localparam logic signed [SW-1:0] YLIM = SW'(IMG_H);

  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           aci_q, aci_d;
  logic                 eksi_q, eksi_d;
  logic signed [16:0]   cos_q, cos_d;
  logic signed [16:0]   sin_q, sin_d;
  logic [CW-1:0]        x_q, x_d;
  logic [CW-1:0]        y_q, y_d;
  logic                 iss_q, iss_d;

  logic                 v1_q;
  logic [CW-1:0]        x1_q, y1_q;
  logic signed [PW-1:0] pa_q, pb_q, pc_q, pd_q;

  logic                 ov_q;
  logic [CW-1:0]        dx_q, dy_q, sx_q, sy_q;
  logic                 cv_q;

  logic                 adv;
  logic                 issue;
  logic                 last_xfer;

  logic signed [CW:0]   xc, yc;
  logic signed [PW-1:0] pa_d, pb_d, pc_d, pd_d;
  logic signed [SW-1:0] sum_x, sum_y, rx, ry, ox, oy;
  logic [CW-1:0]        sx_d, sy_d;
  logic                 cv_d;

  // the whole pipeline moves only when the output slot is free or being taken
  assign adv       = !ov_q || ready;
  assign issue     = (state_q == S_SCAN) && !iss_q;
  assign last_xfer = ov_q && ready && (dx_q == XMAX) && (dy_q == YMAX);

  // frame control: LUT loading, dst raster counters and state sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aci_d   = aci_q;
    eksi_d  = eksi_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    x_d     = x_q;
    y_d     = y_q;
    iss_d   = iss_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          aci_d   = aci_in;
          eksi_d  = eksi_in;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          iss_d   = 1'b0;
          state_d = S_LCOS;
        end
      end
      S_LCOS: begin
        if (cnt_q == LAT) begin
          cos_d   = trig_in;
          cnt_d   = '0;
          state_d = S_LSIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LSIN: begin
        if (cnt_q == LAT) begin
          sin_d   = trig_in;
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SCAN: begin
        if (issue && adv) begin
          if (x_q == XMAX) begin
            x_d = '0;
            if (y_q == YMAX) iss_d = 1'b1;
            else             y_d   = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        if (last_xfer) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      aci_q   <= '0;
      eksi_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      iss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aci_q   <= aci_d;
      eksi_q  <= eksi_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      x_q     <= x_d;
      y_q     <= y_d;
      iss_q   <= iss_d;
    end
  end

  // stage 1 operands: centred coordinates times the captured cos/sin
  assign xc   = $signed({1'b0, x_q}) - XC_OFF;
  assign yc   = $signed({1'b0, y_q}) - YC_OFF;
  assign pa_d = xc * cos_q;
  assign pb_d = yc * sin_q;
  assign pc_d = yc * cos_q;
  assign pd_d = xc * sin_q;

  // stage 1: multiply
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      pa_q <= '0;
      pb_q <= '0;
      pc_q <= '0;
      pd_q <= '0;
    end else if (adv) begin
      v1_q <= issue;
      x1_q <= x_q;
      y1_q <= y_q;
      pa_q <= pa_d;
      pb_q <= pb_d;
      pc_q <= pc_d;
      pd_q <= pd_d;
    end
  end

  // stage 2 operands: sum, round to nearest, shift back to image origin
  assign sum_x = {pa_q[PW-1], pa_q} + {pb_q[PW-1], pb_q};
  assign sum_y = {pc_q[PW-1], pc_q} - {pd_q[PW-1], pd_q};
  assign rx    = (sum_x + RND) >>> 10;
  assign ry    = (sum_y + RND) >>> 10;
  assign ox    = rx + XOFS;
  assign oy    = ry + YOFS;

`ifdef ROT_BOUNDS_CHECK_EN
  logic in_b;
  assign in_b = !ox[SW-1] && (ox < XLIM) && !oy[SW-1] && (oy < YLIM);
  assign cv_d = in_b;
  assign sx_d = in_b ? ox[CW-1:0] : '0;
  assign sy_d = in_b ? oy[CW-1:0] : '0;
`else
  logic unused_hi;
  assign unused_hi = ^{ox[SW-1:CW], oy[SW-1:CW], XLIM, YLIM};
  assign cv_d = 1'b1;
  assign sx_d = ox[CW-1:0];
  assign sy_d = oy[CW-1:0];
`endif

  // stage 2: output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q <= 1'b0;
      dx_q <= '0;
      dy_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      cv_q <= 1'b0;
    end else if (adv) begin
      ov_q <= v1_q;
      dx_q <= x1_q;
      dy_q <= y1_q;
      sx_q <= sx_d;
      sy_q <= sy_d;
      cv_q <= v1_q && cv_d;
    end
  end

  assign aci         = aci_q;
  assign eksi        = eksi_q;
  assign mode_switch = (state_q == S_LSIN);
  assign dst_x       = dx_q;
  assign dst_y       = dy_q;
  assign src_x       = sx_q;
  assign src_y       = sy_q;
  assign coord_valid = cv_q;
  assign out_valid   = ov_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_rot_coord_gen.sv
// tb_rot_coord_gen: scoreboard bench for rot_coord_gen.
// Honours ROT_BOUNDS_CHECK_EN the same way as the design.
module tb_rot_coord_gen;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    aci_in;
  logic          eksi_in;
  logic [2:0]    aci;
  logic          eksi;
  logic          mode_switch;
  logic [16:0]   trig_in = '0;
  logic [CW-1:0] dst_x, dst_y, src_x, src_y;
  logic          coord_valid;
  logic          out_valid;
  logic          ready;
  logic          busy;
  logic          done;

  rot_coord_gen #(.IMG_W(W), .IMG_H(H), .CW(CW), .LUT_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .aci_in(aci_in), .eksi_in(eksi_in),
    .aci(aci), .eksi(eksi), .mode_switch(mode_switch),
    .trig_in(trig_in),
    .dst_x(dst_x), .dst_y(dst_y), .src_x(src_x), .src_y(src_y),
    .coord_valid(coord_valid), .out_valid(out_valid),
    .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dx;
    int dy;
    int sx;
    int sy;
    int cv;
  } beat_t;

  beat_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int beats = 0;
  int done_cnt = 0;
  int dstage = 0;
  int cos_v = 0;
  int sin_v = 0;
  int f00_sx, f00_sy, f00_cv;
  int f32_sx, f32_sy, f32_cv;

  // one-cycle LUT stage model
  always @(posedge clk) trig_in <= 17'(mode_switch ? sin_v : cos_v);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rnd_sh(input int v);
    return (v + 512) >>> 10;
  endfunction

  // reference: every dst of the frame mapped through the inverse rotation
  task automatic push_frame(input int c, input int s);
    beat_t b;
    int xc, yc, ax, ay;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        xc = x - W / 2;
        yc = y - H / 2;
        ax = rnd_sh(xc * c + yc * s) + W / 2;
        ay = rnd_sh(yc * c - xc * s) + H / 2;
        b.dx = x;
        b.dy = y;
`ifdef ROT_BOUNDS_CHECK_EN
        if (ax >= 0 && ax < W && ay >= 0 && ay < H) begin
          b.cv = 1; b.sx = ax; b.sy = ay;
        end else begin
          b.cv = 0; b.sx = 0; b.sy = 0;
        end
`else
        b.cv = 1;
        b.sx = ax & ((1 << CW) - 1);
        b.sy = ay & ((1 << CW) - 1);
`endif
        q.push_back(b);
      end
    end
  endtask

  logic        p_hold = 1'b0;
  logic [32:0] p_out;

  // monitor: scoreboard pops, stall hold, done timing
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (done) done_cnt++;
      if (dstage == 1) begin
        chk("done_pulse", 64'(done), 64'd1);
        dstage = 2;
      end else if (dstage == 2) begin
        chk("done_end_idle", 64'({done, busy}), 64'd0);
        dstage = 0;
      end
      if (p_hold)
        chk("stall_hold",
            64'({dst_x, dst_y, src_x, src_y, coord_valid}), 64'(p_out));
      if (out_valid && ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'({dst_x, dst_y}), 64'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("beat", 64'({dst_x, dst_y, src_x, src_y, coord_valid}),
              64'({CW'(e.dx), CW'(e.dy), CW'(e.sx), CW'(e.sy), 1'(e.cv)}));
          beats++;
          if (e.dx == 0 && e.dy == 0) begin
            f00_sx = int'(src_x); f00_sy = int'(src_y);
            f00_cv = int'(coord_valid);
          end
          if (e.dx == 32 && e.dy == 0) begin
            f32_sx = int'(src_x); f32_sy = int'(src_y);
            f32_cv = int'(coord_valid);
          end
          if (q.size() == 0) dstage = 1;
        end
      end
      p_hold = out_valid && !ready;
      p_out  = {dst_x, dst_y, src_x, src_y, coord_valid};
    end else begin
      p_hold = 1'b0;
    end
  end

  task automatic run_frame(input int c, input int s, input bit rnd_rdy,
                           input bit stall, input bit inj, input int rst_at);
    int dc0;
    logic [2:0] a;
    logic e;
    bit stalled;
    bit aborted;
    cos_v = c;
    sin_v = s;
    a = 3'($urandom);
    e = 1'($urandom);
    aci_in = a;
    eksi_in = e;
    ready = 1'b1;
    beats = 0;
    dc0 = done_cnt;
    stalled = 0;
    aborted = 0;
    push_frame(c, s);
    @(posedge clk) #1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    chk("latch_aci_eksi", 64'({aci, eksi}), 64'({a, e}));
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 20000 && done_cnt == dc0; cyc++) begin
      @(posedge clk) #1;
      ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall && !stalled && beats >= 1000) begin
        stalled = 1;
        ready = 1'b0;
        repeat (5) @(posedge clk) #1;
        ready = 1'b1;
      end
      if (inj && cyc == 60) begin
        aci_in = ~a;
        eksi_in = ~e;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
      end
      if (rst_at > 0 && beats >= rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("reset_outputs",
            64'({aci, eksi, mode_switch, dst_x, dst_y, src_x, src_y,
                 coord_valid, out_valid, busy, done}), 64'd0);
        q.delete();
        dstage = 0;
        @(posedge clk);
        @(posedge clk) #1;
        reset = 1'b0;
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      repeat (3) @(posedge clk);
      chk("no_done_after_reset", 64'(done_cnt), 64'(dc0));
    end else begin
      chk("frame_done_seen", 64'(done_cnt), 64'(dc0 + 1));
      repeat (3) @(posedge clk);
      #1;
      chk("beat_count", 64'(beats), 64'(W * H));
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("idle_after_frame", 64'({busy, out_valid}), 64'd0);
      if (inj) chk("start_ignored_aci", 64'({aci, eksi}), 64'({a, e}));
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    aci_in = '0;
    eksi_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        64'({aci, eksi, mode_switch, dst_x, dst_y, src_x, src_y,
             coord_valid, out_valid, busy, done}), 64'd0);
    reset = 1'b0;

    run_frame(1024, 0, 0, 0, 0, 0);

    run_frame(0, 1024, 0, 0, 0, 0);
`ifdef ROT_BOUNDS_CHECK_EN
    chk("sin90_00", 64'({f00_sx[7:0], f00_sy[7:0], f00_cv[0]}),
        64'({8'd0, 8'd0, 1'b0}));
`else
    chk("sin90_00", 64'({f00_sx[7:0], f00_sy[7:0], f00_cv[0]}),
        64'({8'd0, 8'd64, 1'b1}));
`endif

    run_frame(724, 724, 0, 1, 0, 0);
    chk("rot45_32_0", 64'({f32_sx[7:0], f32_sy[7:0], f32_cv[0]}),
        64'({8'd9, 8'd9, 1'b1}));

    run_frame(int'($urandom_range(0, 2048)) - 1024,
              int'($urandom_range(0, 2048)) - 1024, 1, 0, 1, 0);
    run_frame(int'($urandom_range(0, 2048)) - 1024,
              int'($urandom_range(0, 2048)) - 1024, 1, 0, 0, 100);
    run_frame(int'($urandom_range(0, 2048)) - 1024,
              -int'($urandom_range(0, 1024)), 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_coord_gen.md
ROT_COORD_GEN -- requirements
Module: rot_coord_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 64: image width in pixels; power of two, at most 2^(CW-1).
REQ-002 SHALL have parameter IMG_H, default 64: image height in pixels; power of two, at most 2^(CW-1).
REQ-003 SHALL have parameter CW, default 8: coordinate width in bits.
REQ-004 SHALL have parameter LUT_LAT, default 1: cycles from aci/mode_switch change to a stable trig_in.
REQ-005 SHALL have ports clk  input  1  the single clock; reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start  input  1  begin frame (pulse); aci_in  input  3  angle code; eksi_in  input  1  negative-angle flag.
REQ-007 SHALL have ports aci  output  3, eksi  output  1, mode_switch  output  1 (1=sin, 0=cos): drive to the sin/cos LUT stage.
REQ-008 SHALL have port trig_in  input  17  signed Q7.10 sin/cos value returned by the LUT stage.
REQ-009 SHALL have ports dst_x, dst_y, src_x, src_y  output  CW each; coord_valid  output  1; out_valid  output  1; ready  input  1; busy  output  1; done  output  1.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD_COS -> LOAD_SIN -> SCAN -> DONE -> IDLE.
REQ-011 IDLE: on start=1, latch aci_in/eksi_in to aci/eksi, go to LOAD_COS; start while not IDLE ignored.
REQ-012 LOAD_COS: mode_switch=0 for LUT_LAT+1 cycles, capture trig_in as COS on last cycle, go to LOAD_SIN.
REQ-013 LOAD_SIN: mode_switch=1 for LUT_LAT+1 cycles, capture trig_in as SIN on last cycle, go to SCAN.
REQ-014 SCAN: raster-scan dst (x inner 0..IMG_W-1, y outer 0..IMG_H-1); one dst issued per cycle when pipeline not stalled.
REQ-015 Inverse map about centre: xc=x-IMG_W/2, yc=y-IMG_H/2; src_x=R(xc*COS+yc*SIN)+IMG_W/2; src_y=R(yc*COS-xc*SIN)+IMG_H/2.
REQ-016 Products SHALL be full-precision signed (CW+1)x17; sums one bit wider; R() adds 512 then arithmetic-shifts right 10.
REQ-017 Latency SHALL be exactly 2 cycles (multiply stage, sum/round stage) from dst issue to out_valid with that dst.
REQ-018 Handshake: transfer when out_valid&ready; with ready=0 all outputs and pipeline hold; no beat lost or duplicated.
REQ-019 After the beat (IMG_W-1, IMG_H-1) transfers, go to DONE; done=1 for exactly one cycle, then IDLE.
REQ-020 busy=1 in every state except IDLE.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE and all outputs to 0 (aci, eksi, mode_switch, coords, valids, busy, done).
REQ-022 Reset mid-frame SHALL abandon the frame; no done pulse; next start begins a fresh frame at dst (0,0).

Configuration
REQ-023 Macro ROT_BOUNDS_CHECK_EN defined: coord_valid=1 only if 0<=src_x<IMG_W and 0<=src_y<IMG_H, else 0; src coordinates output 0 when invalid.
REQ-024 Macro ROT_BOUNDS_CHECK_EN undefined: coord_valid=out_valid; src coordinates are the low CW bits of the result (wrap).

Verification
REQ-025 start, COS=1024, SIN=0 -> src==dst for all 4096 beats; done one cycle after last beat; busy low after.
REQ-026 COS=0, SIN=1024, dst (0,0) -> src_x=0, src_y=64; with ROT_BOUNDS_CHECK_EN coord_valid=0, src=0; without, src_y=64 (0x40).
REQ-027 COS=724, SIN=724 (45 deg), dst (32,0) -> src_x=9, src_y=9, coord_valid=1.
REQ-028 ready held 0 for 5 cycles mid-scan -> outputs frozen; beat sequence contiguous, no gaps or repeats.
REQ-029 reset asserted at beat 100 -> all outputs 0 within the same cycle, no done; new start restarts at (0,0).
REQ-030 start pulsed during SCAN -> ignored; frame completes with exactly IMG_W*IMG_H beats.
